// File: rtl/burst_ram_if.sv
// burst_ram_if: command/data bus between a burst master and burst_ram.
//
// Handshake: there is no ready signal. br_cmd_en is a single-cycle valid
// pulse qualifying br_cmd/br_addr (and beat-0 write data/mask). The slave
// only takes it on a rising edge where it is calibrated and idle; a pulse
// at any other time is dropped. Write beats 1..3 follow on the next three
// edges without any qualifier. br_rd_data is meaningful only while
// br_rd_data_valid is 1.
interface burst_ram_if #(
  parameter int ADDRESS_BITWIDTH = 21
);
  logic                        br_cmd;
  logic                        br_cmd_en;
  logic [ADDRESS_BITWIDTH-1:0] br_addr;
  logic [63:0]                 br_wr_data;
  logic [7:0]                  br_data_mask;
  logic [63:0]                 br_rd_data;
  logic                        br_rd_data_valid;

  modport master (
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid
  );

  modport slave (
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid
  );
endinterface

// File: rtl/burst_ram.sv
// burst_ram: 64-bit wide RAM with fixed 4-beat wrapping bursts, a fixed
// read latency and a calibration delay after reset.
// Optional feature macro: BURST_RAM_PROTOCOL_CHECK_EN enables a sticky
// protocol_error flag; without it protocol_error is tied to 0.
module burst_ram #(
  parameter int ADDRESS_BITWIDTH = 21,
  parameter int DEPTH_BITWIDTH   = 12,
  parameter int ADDRESSING_MODE  = 0,
  parameter int READ_LATENCY     = 12,
  parameter int CALIB_CYCLES     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  burst_ram_if.slave bus,
  output logic       init_calib,
  output logic       protocol_error,
  output logic [2:0] state_dbg
);

  // Address units are 2^ADDRESSING_MODE bytes, storage words are 8 bytes.
  localparam int SHIFT   = 3 - ADDRESSING_MODE;
  localparam int CNT_MAX = (CALIB_CYCLES > READ_LATENCY) ? CALIB_CYCLES : READ_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DEPTH   = 1 << DEPTH_BITWIDTH;

  typedef enum logic [2:0] {
    S_CALIB       = 3'd0,
    S_IDLE        = 3'd1,
    S_READ_WAIT   = 3'd2,
    S_READ_BURST  = 3'd3,
    S_WRITE_BURST = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [1:0]                  beat_q;
  logic [DEPTH_BITWIDTH-1:0]   start_idx_q;
  logic [ADDRESS_BITWIDTH-1:0] addr_w;
  logic [DEPTH_BITWIDTH-1:0]   cmd_idx;
  logic [DEPTH_BITWIDTH-1:0]   beat_idx;
  logic                        calib_done;
  logic                        wait_done;
  logic                        cmd_wr;
  logic                        cmd_rd;
  logic                        mem_we;
  logic [DEPTH_BITWIDTH-1:0]   mem_widx;
  logic [7:0]                  mem_wmask;
  logic                        rd_fetch;
  logic [63:0]                 rd_data_q;
  logic [63:0]                 mem [DEPTH];

  // Word index: upper address bits beyond the array depth alias.
  assign addr_w   = bus.br_addr;
  assign cmd_idx  = DEPTH_BITWIDTH'(addr_w >> SHIFT);
  // Beats wrap inside the aligned 4-word block of the start address.
  assign beat_idx = {start_idx_q[DEPTH_BITWIDTH-1:2], start_idx_q[1:0] + beat_q};

  assign calib_done = (cnt_q == CNT_W'(CALIB_CYCLES - 1));
  assign wait_done  = (cnt_q == CNT_W'(READ_LATENCY - 1));
  assign cmd_wr     = (state_q == S_IDLE) && bus.br_cmd_en && bus.br_cmd;
  assign cmd_rd     = (state_q == S_IDLE) && bus.br_cmd_en && !bus.br_cmd;

  assign bus.br_rd_data = rd_data_q;
  assign state_dbg      = state_q;

  // State register; reset always lands in calibration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CALIB;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CALIB:       if (calib_done) state_d = S_IDLE;
      S_IDLE: begin
        if (cmd_wr)      state_d = S_WRITE_BURST;
        else if (cmd_rd) state_d = S_READ_WAIT;
      end
      S_READ_WAIT:   if (wait_done) state_d = S_READ_BURST;
      // beat_q wraps to 0 once all four beats have been presented.
      S_READ_BURST:  if (beat_q == 2'd0) state_d = S_IDLE;
      S_WRITE_BURST: if (beat_q == 2'd3) state_d = S_IDLE;
      default:       state_d = S_CALIB;
    endcase
  end

  // Outputs and memory strobes decoded from the current state.
  always_comb begin
    init_calib           = (state_q != S_CALIB);
    bus.br_rd_data_valid = (state_q == S_READ_BURST);
    mem_we               = 1'b0;
    mem_widx             = beat_idx;
    mem_wmask            = 8'hFF;
    rd_fetch             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_wr) begin
          mem_we    = 1'b1;
          mem_widx  = cmd_idx;
          mem_wmask = bus.br_data_mask;
        end
      end
      S_READ_WAIT:  rd_fetch = wait_done;
      S_READ_BURST: rd_fetch = 1'b1;
      S_WRITE_BURST: begin
        mem_we    = 1'b1;
        mem_wmask = bus.br_data_mask;
      end
      default: ;
    endcase
  end

  // Shared cycle counter (calibration / read latency), beat pointer and
  // latched burst start index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      beat_q      <= 2'd0;
      start_idx_q <= '0;
    end else begin
      case (state_q)
        S_CALIB: cnt_q <= calib_done ? '0 : cnt_q + 1'b1;
        S_IDLE: begin
          cnt_q <= '0;
          if (cmd_wr) begin
            start_idx_q <= cmd_idx;
            beat_q      <= 2'd1;   // beat 0 is written on the accept edge
          end else if (cmd_rd) begin
            start_idx_q <= cmd_idx;
            beat_q      <= 2'd0;
          end
        end
        S_READ_WAIT: begin
          if (wait_done) begin
            cnt_q  <= '0;
            beat_q <= beat_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_READ_BURST, S_WRITE_BURST: beat_q <= beat_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array with byte-masked writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (!mem_wmask[i]) mem[mem_widx][i*8 +: 8] <= bus.br_wr_data[i*8 +: 8];
      end
    end
    if (rd_fetch) rd_data_q <= mem[beat_idx];
  end

`ifdef BURST_RAM_PROTOCOL_CHECK_EN
  logic perr_q;

  // Sticky flag: any command pulse outside IDLE (this also covers a
  // command re-asserted in the middle of a write burst).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     perr_q <= 1'b0;
    else if (bus.br_cmd_en && (state_q != S_IDLE)) perr_q <= 1'b1;
  end

  assign protocol_error = perr_q;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: directed bench for burst_ram (byte addressing, default
// latency and calibration length).
module tb_burst_ram;

  localparam int AW = 21;
  localparam int DW = 12;
  localparam int RL = 12;
  localparam int CC = 32;

  localparam logic [2:0] ST_CALIB       = 3'd0;
  localparam logic [2:0] ST_IDLE        = 3'd1;
  localparam logic [2:0] ST_READ_WAIT   = 3'd2;
  localparam logic [2:0] ST_WRITE_BURST = 3'd4;

`ifdef BURST_RAM_PROTOCOL_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] WF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] WJ = 64'hBAD0_BAD0_BAD0_BAD0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_calib;
  logic       protocol_error;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  burst_ram_if #(.ADDRESS_BITWIDTH(AW)) bus ();

  burst_ram #(
    .ADDRESS_BITWIDTH(AW),
    .DEPTH_BITWIDTH  (DW),
    .ADDRESSING_MODE (0),
    .READ_LATENCY    (RL),
    .CALIB_CYCLES    (CC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .init_calib    (init_calib),
    .protocol_error(protocol_error),
    .state_dbg     (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.br_cmd_en    = 1'b0;
    bus.br_cmd       = 1'b0;
    bus.br_addr      = '0;
    bus.br_wr_data   = '0;
    bus.br_data_mask = '0;
  endtask

  // Runs the calibration window after reset release; a write command is
  // pulsed at edge pulse_k and must be ignored.
  task automatic run_calib(input string tag, input int pulse_k);
    for (int k = 1; k <= CC + 1; k++) begin
      bus.br_cmd_en  = (k == pulse_k);
      bus.br_cmd     = 1'b1;
      bus.br_addr    = AW'('h40);
      bus.br_wr_data = WJ;
      @(negedge clk);
      check({tag, "_init_calib"}, 64'(init_calib), 64'(k >= CC));
      check({tag, "_rd_valid"}, 64'(bus.br_rd_data_valid), 64'd0);
    end
    drive_idle();
    check({tag, "_state_idle"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  task automatic write_burst(input string tag, input logic [AW-1:0] addr,
                             input logic [0:3][63:0] d, input logic [0:3][7:0] m);
    bus.br_cmd_en    = 1'b1;
    bus.br_cmd       = 1'b1;
    bus.br_addr      = addr;
    bus.br_wr_data   = d[0];
    bus.br_data_mask = m[0];
    @(negedge clk);
    check({tag, "_state_wr"}, 64'(state_dbg), 64'(ST_WRITE_BURST));
    bus.br_cmd_en = 1'b0;
    for (int b = 1; b < 4; b++) begin
      bus.br_wr_data   = d[b];
      bus.br_data_mask = m[b];
      @(negedge clk);
    end
    drive_idle();
    check({tag, "_state_done"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  // Read with exact latency checking; inject_k > 0 pulses a stray write
  // command at edge N+inject_k.
  task automatic read_burst(input string tag, input logic [AW-1:0] addr,
                            input logic [0:3][63:0] e, input int inject_k);
    for (int b = 0; b < 4; b++) exp_q.push_back(e[b]);
    bus.br_cmd_en = 1'b1;
    bus.br_cmd    = 1'b0;
    bus.br_addr   = addr;
    @(negedge clk);
    check({tag, "_state_wait"}, 64'(state_dbg), 64'(ST_READ_WAIT));
    for (int k = 1; k <= RL + 4; k++) begin
      bus.br_cmd_en  = (k == inject_k);
      bus.br_cmd     = 1'b1;
      bus.br_wr_data = WJ;
      @(negedge clk);
      check({tag, "_valid"}, 64'(bus.br_rd_data_valid), 64'(k >= RL && k <= RL + 3));
      if (k >= RL && k <= RL + 3 && exp_q.size() > 0)
        check({tag, "_data"}, bus.br_rd_data, exp_q.pop_front());
    end
    drive_idle();
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_state_idle"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  initial begin
    drive_idle();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.br_rd_data_valid), 64'd0);
    check("rst_init_calib", 64'(init_calib), 64'd0);
    check("rst_perr", 64'(protocol_error), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_CALIB));

    // Calibration with a command pulsed mid-window
    rst_n = 1'b1;
    run_calib("calib1", 10);
    check("calib1_perr", 64'(protocol_error), 64'(PCHK));

    // Basic write then read of byte address 0x40 (words 8..11)
    write_burst("wr40", AW'('h40), {W1, W2, W3, W4}, {8'h00, 8'h00, 8'h00, 8'h00});
    read_burst("rd40", AW'('h40), {W1, W2, W3, W4}, 0);

    // Start at word 10, offset 2: wraps within the block
    read_burst("rd50", AW'('h50), {W3, W4, W1, W2}, 0);

    // Byte mask: low four bytes of beat 0 kept, other beats fully masked
    write_burst("wr100a", AW'('h100), {WA, WA, WA, WA}, {8'h00, 8'h00, 8'h00, 8'h00});
    write_burst("wr100m", AW'('h100), {WF, WF, WF, WF}, {8'h0F, 8'hFF, 8'hFF, 8'hFF});
    read_burst("rd100", AW'('h100),
               {64'hFFFF_FFFF_AAAA_AAAA, WA, WA, WA}, 0);

    // Stray command during READ_WAIT is ignored
    read_burst("rd40_inj", AW'('h40), {W1, W2, W3, W4}, 3);
    check("inj_perr", 64'(protocol_error), 64'(PCHK));
    read_burst("rd40_after", AW'('h40), {W1, W2, W3, W4}, 0);

    // Reset while beat 2 is on the bus
    bus.br_cmd_en = 1'b1;
    bus.br_cmd    = 1'b0;
    bus.br_addr   = AW'('h40);
    @(negedge clk);
    drive_idle();
    repeat (RL + 2) @(negedge clk);
    check("mid_valid_b2", 64'(bus.br_rd_data_valid), 64'd1);
    check("mid_data_b2", bus.br_rd_data, W3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.br_rd_data_valid), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'(ST_CALIB));
    check("mid_rst_perr", 64'(protocol_error), 64'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_valid_hold", 64'(bus.br_rd_data_valid), 64'd0);
    rst_n = 1'b1;
    run_calib("calib2", 5);

    // Memory retained across reset; calibration-time write ignored
    read_burst("rd40_retained", AW'('h40), {W1, W2, W3, W4}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 21, width of br_addr.
REQ-002 SHALL have parameter DEPTH_BITWIDTH, default 12, log2 of the number of 64-bit storage words.
REQ-003 SHALL have parameter ADDRESSING_MODE, default 0: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit address units.
REQ-004 SHALL have parameter READ_LATENCY, default 12, cycles from command sample to first read beat; legal range 2..63.
REQ-005 SHALL have parameter CALIB_CYCLES, default 32, cycles from reset release to init_calib.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port br_cmd  input  1  0: read, 1: write.
REQ-009 SHALL have port br_cmd_en  input  1  command and address valid, one cycle.
REQ-010 SHALL have port br_addr  input  ADDRESS_BITWIDTH  burst start address in ADDRESSING_MODE units.
REQ-011 SHALL have port br_wr_data  input  64  write beat data.
REQ-012 SHALL have port br_data_mask  input  8  per-beat byte mask; bit i = 1 means byte i is not written.
REQ-013 SHALL have port br_rd_data  output  64  read beat data.
REQ-014 SHALL have port br_rd_data_valid  output  1  br_rd_data holds a valid beat.
REQ-015 SHALL have port init_calib  output  1  ready to accept commands.
REQ-016 SHALL have port protocol_error  output  1  sticky protocol violation flag.

Function
REQ-017 SHALL compute word index = br_addr >> (3 - ADDRESSING_MODE), truncated to DEPTH_BITWIDTH bits; upper bits alias.
REQ-018 SHALL run a state machine with the states CALIB, IDLE, READ_WAIT, READ_BURST and WRITE_BURST.
REQ-019 SHALL count clock cycles in CALIB and, after CALIB_CYCLES cycles, set init_calib to 1 and move to IDLE; init_calib stays 1 until reset.
REQ-020 SHALL accept a command only in IDLE, and only when br_cmd_en is 1 at a rising edge.
REQ-021 SHALL treat every burst as 4 beats of 64 bits; beat k uses the word index with its low 2 bits replaced by (start low 2 bits + k) mod 4 (wrap within an aligned 4-word block).
REQ-022 SHALL, for a write, store beat 0 from br_wr_data/br_data_mask sampled on the same edge as br_cmd_en, then beats 1..3 on the next 3 consecutive edges in WRITE_BURST, then return to IDLE.
REQ-023 SHALL, for a read accepted at edge N, assert br_rd_data_valid during exactly the 4 consecutive cycles after edges N+READ_LATENCY .. N+READ_LATENCY+3, presenting beats 0..3 in order, then return to IDLE.
REQ-024 SHALL drive br_rd_data_valid to 0 at all other times; br_rd_data is don't-care when not valid.
REQ-025 SHALL return, for a read following a write to the same block, the newly written data, provided the read is accepted after the write burst completes.
REQ-026 SHALL ignore br_cmd_en outside IDLE, including during CALIB; the ignored command SHALL have no effect on state or memory.
REQ-027 SHALL NOT enforce a command interval; a new command is accepted on the first IDLE cycle after a burst ends.

Reset
REQ-028 SHALL, while rst_n is 0, hold br_rd_data_valid=0, init_calib=0, protocol_error=0, state=CALIB, and clear the calibration counter.
REQ-029 SHALL abort any burst in progress when reset is asserted mid-operation; a partially written burst keeps its beats already stored; memory contents are retained, not cleared.

Configuration
REQ-030 SHALL, when BURST_RAM_PROTOCOL_CHECK_EN is defined, set protocol_error to 1 on any br_cmd_en seen outside IDLE, or on a write with br_data_mask != 0 beyond beat 0 when br_cmd_en is re-asserted mid-burst; protocol_error stays 1 until reset.
REQ-031 SHALL, when BURST_RAM_PROTOCOL_CHECK_EN is not defined, tie protocol_error to 0 and omit the checking logic.

Verification
REQ-032 SHALL cover: reset release, CALIB_CYCLES=32 -> init_calib=0 through cycle 31, init_calib=1 from cycle 32; br_cmd_en during CALIB ignored.
REQ-033 SHALL cover: write to byte address 0x40 with beats 0x1111..1111, 0x2222..2222, 0x3333..3333, 0x4444..4444, then a read of 0x40 -> valid for 4 cycles starting READ_LATENCY=12 edges after the read command, with the same 4 words in order.
REQ-034 SHALL cover: read at address 0x50 (word 10, offset 2) after the REQ-033 write -> beats returned in order 0x3333.., 0x4444.., 0x1111.., 0x2222.. (wrap).
REQ-035 SHALL cover: write 0xFFFF_FFFF_FFFF_FFFF over 0xAAAA..AAAA with mask 0x0F on beat 0 -> read returns 0xFFFF_FFFF_AAAA_AAAA.
REQ-036 SHALL cover: br_cmd_en pulsed during READ_WAIT -> command ignored, original burst unaffected; protocol_error=1 only with BURST_RAM_PROTOCOL_CHECK_EN defined.
REQ-037 SHALL cover: rst_n dropped during READ_BURST beat 2 -> br_rd_data_valid=0 immediately, with no further beats after release.
